// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//
// Shared definitions for the direct-mapped, 16-set cache controller.
//
// Contents:
//   ADDR_W / OFFSET_W / IDX_W / TAG_W  address geometry (32-byte lines)
//   ctrl_state_e                       controller state encoding
//   addr_tag / addr_idx                field extraction from a CPU byte address
//   line_addr                          rebuilds a line-aligned memory address
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int IDX_W    = 4;
  localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    ALLOC,
    FILL,
    REREAD
  } ctrl_state_e;

  // The tag is everything above the set index.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  // The set index sits directly above the line offset.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: IDX_W];
  endfunction

  // Memory transfers are always whole lines, so the offset is zeroed.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// ---------------------------------------------------------------------------
// cache_perf_cnt
//
// Hit / miss / writeback event counters for the cache controller. The whole
// module only exists when CACHE_PERF_CNT_EN is defined, so the default build
// carries no orphan top-level module.
//
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset, clears all counters
//   hit_evt_i   one-cycle pulse per first-lookup hit
//   miss_evt_i  one-cycle pulse per lookup miss
//   wb_evt_i    one-cycle pulse per entry into writeback
//   hit_cnt_o   hit count  (wraps at 2^32)
//   miss_cnt_o  miss count (wraps at 2^32)
//   wb_cnt_o    writeback count (wraps at 2^32)
// ---------------------------------------------------------------------------
`ifdef CACHE_PERF_CNT_EN
module cache_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hit_evt_i,
  input  logic        miss_evt_i,
  input  logic        wb_evt_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] wb_cnt_o
);

  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q,   wb_cnt_d;

  // Each counter advances by one on its event pulse; plain modulo-2^32
  // addition gives the wrap-around for free.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (hit_evt_i)  hit_cnt_d  = hit_cnt_q  + 32'd1;
    if (miss_evt_i) miss_cnt_d = miss_cnt_q + 32'd1;
    if (wb_evt_i)   wb_cnt_d   = wb_cnt_q   + 32'd1;
  end

  // Counter registers, cleared together with the controller.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;

endmodule
`endif

// File: rtl/cache_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cache_ctrl_fsm
//
// Controller for a direct-mapped, 16-set, 32-byte-line cache. Walks each CPU
// request through lookup, hit service, dirty-victim writeback and line refill,
// and drives the tag/valid/data/dirty arrays (1-cycle registered read,
// active-high chip enable csb0) plus the physical-memory handshake.
//
// Optional feature (macro CACHE_PERF_CNT_EN):
//   adds hit_cnt / miss_cnt / wb_cnt outputs backed by cache_perf_cnt.
//
// Ports:
//   clk0, reset_n             clock, synchronous active-low reset
//   mem_read, mem_write       CPU request, held until mem_resp
//   mem_addr                  CPU byte address
//   mem_resp                  one-cycle completion pulse to the CPU
//   csb0, web0                array enable / tag-valid-data write strobe
//   set_idx                   array address
//   tag_din, tag_dout         tag write data / tag read data
//   valid_din, valid_dout     valid write data / valid read data
//   data_sel                  data source: 0 = CPU write merge, 1 = pmem line
//   dirty_web0, dirty_addr0   dirty array write strobe / address
//   dirty_din0, dirty_dout0   dirty write data / dirty read data
//   pmem_read, pmem_write     line fill / victim writeback, held until pmem_resp
//   pmem_addr                 line-aligned physical-memory address
//   pmem_resp                 physical-memory completion pulse
//   hit_cnt, miss_cnt, wb_cnt performance counters (CACHE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module cache_ctrl_fsm
  import cache_pkg::*;
(
  input  logic              clk0,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_resp,
  output logic              csb0,
  output logic              web0,
  output logic [IDX_W-1:0]  set_idx,
  output logic [TAG_W-1:0]  tag_din,
  input  logic [TAG_W-1:0]  tag_dout,
  output logic              valid_din,
  input  logic              valid_dout,
  output logic              data_sel,
  output logic              dirty_web0,
  output logic [IDX_W-1:0]  dirty_addr0,
  output logic              dirty_din0,
  input  logic              dirty_dout0,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  input  logic              pmem_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
`endif
);

  ctrl_state_e      state_q,     state_d;
  logic [TAG_W-1:0] req_tag_q,   req_tag_d;
  logic [IDX_W-1:0] req_idx_q,   req_idx_d;
  logic             req_write_q, req_write_d;
  logic [TAG_W-1:0] vic_tag_q,   vic_tag_d;

  logic             lookup_hit;
  logic             addr_offset_unused;

  // The byte offset inside a line never matters to the controller; it is
  // folded here so the unused bits are visibly accounted for.
  assign addr_offset_unused = ^mem_addr[OFFSET_W-1:0];

  // The arrays were read on the previous cycle, so in LOOKUP their outputs
  // describe the requested set and can be compared against the latched tag.
  assign lookup_hit = valid_dout && (tag_dout == req_tag_q);

  // State and request registers. Reset returns to IDLE and drops the latched
  // request; any pmem transfer in flight is simply abandoned, which is why
  // physical memory has to be reset alongside the controller.
  always_ff @(posedge clk0) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_write_q <= 1'b0;
      vic_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_write_q <= req_write_d;
      vic_tag_q   <= vic_tag_d;
    end
  end

  // Next-state and output decode. Every output defaults to 0 so IDLE without
  // a request is quiet. In IDLE the array address comes straight from the
  // CPU address because the latched copy only becomes valid next cycle; in
  // every other state the latched index is used so mid-request address
  // changes are ignored. Requests are not accepted while reset is held, which
  // keeps every output at 0 for the whole reset window. A simultaneous read
  // and write is latched as a write.
  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_write_d = req_write_q;
    vic_tag_d   = vic_tag_q;

    mem_resp    = 1'b0;
    csb0        = 1'b0;
    web0        = 1'b0;
    set_idx     = '0;
    tag_din     = '0;
    valid_din   = 1'b0;
    data_sel    = 1'b0;
    dirty_web0  = 1'b0;
    dirty_din0  = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    pmem_addr   = '0;

    if (state_q != IDLE) begin
      set_idx = req_idx_q;
    end

    unique case (state_q)
      IDLE: begin
        if (reset_n && (mem_read || mem_write)) begin
          req_tag_d   = addr_tag(mem_addr);
          req_idx_d   = addr_idx(mem_addr);
          req_write_d = mem_write;
          csb0        = 1'b1;
          set_idx     = addr_idx(mem_addr);
          state_d     = LOOKUP;
        end
      end

      LOOKUP: begin
        if (lookup_hit) begin
          mem_resp = 1'b1;
          state_d  = IDLE;
          if (req_write_q) begin
            csb0       = 1'b1;
            web0       = 1'b1;
            data_sel   = 1'b0;
            tag_din    = req_tag_q;
            valid_din  = 1'b1;
            dirty_web0 = 1'b1;
            dirty_din0 = 1'b1;
          end
        end else if (valid_dout && dirty_dout0) begin
          vic_tag_d = tag_dout;
          state_d   = WB;
        end else begin
          state_d = ALLOC;
        end
      end

      WB: begin
        pmem_write = 1'b1;
        pmem_addr  = line_addr(vic_tag_q, req_idx_q);
        if (pmem_resp) begin
          pmem_write = 1'b0;
          state_d    = ALLOC;
        end
      end

      ALLOC: begin
        pmem_read = 1'b1;
        pmem_addr = line_addr(req_tag_q, req_idx_q);
        if (pmem_resp) begin
          state_d = FILL;
        end
      end

      FILL: begin
        csb0       = 1'b1;
        web0       = 1'b1;
        data_sel   = 1'b1;
        tag_din    = req_tag_q;
        valid_din  = 1'b1;
        dirty_web0 = 1'b1;
        dirty_din0 = 1'b0;
        state_d    = REREAD;
      end

      REREAD: begin
        csb0    = 1'b1;
        state_d = LOOKUP;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    dirty_addr0 = set_idx;
  end

`ifdef CACHE_PERF_CNT_EN
  logic reread_q;
  logic hit_evt;
  logic miss_evt;
  logic wb_evt;

  // REREAD always hands over to LOOKUP, so this flag marks exactly the
  // lookup that follows a refill; its guaranteed hit must not be counted.
  always_ff @(posedge clk0) begin
    if (!reset_n) begin
      reread_q <= 1'b0;
    end else begin
      reread_q <= (state_q == REREAD);
    end
  end

  assign hit_evt  = (state_q == LOOKUP) && lookup_hit && !reread_q;
  assign miss_evt = (state_q == LOOKUP) && !lookup_hit;
  assign wb_evt   = (state_q == LOOKUP) && (state_d == WB);

  cache_perf_cnt u_perf_cnt (
    .clk_i      (clk0),
    .rst_ni     (reset_n),
    .hit_evt_i  (hit_evt),
    .miss_evt_i (miss_evt),
    .wb_evt_i   (wb_evt),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
    .wb_cnt_o   (wb_cnt)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_fsm
//
// Bench for cache_ctrl_fsm. Surrounds the controller with behavioural
// tag/valid/dirty arrays (1-cycle read) and a fixed-latency physical memory,
// keeps a shadow copy of the cache contents, and predicts for every request
// the pmem traffic, refill writes and response latency it must produce.
// Build with CACHE_PERF_CNT_EN defined to also cover the event counters.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_fsm;

  localparam int PMEM_LAT   = 3;
  localparam int RESP_BOUND = 200;

  typedef struct {
    int         lat;
    bit         isWrite;
    logic [3:0] idx;
  } respExp_t;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
  } pmemExp_t;

  typedef struct {
    logic [22:0] tag;
    logic [3:0]  idx;
  } fillExp_t;

  logic        clk0;
  logic        reset_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic        mem_resp;
  logic        csb0;
  logic        web0;
  logic [3:0]  set_idx;
  logic [22:0] tag_din;
  logic [22:0] tag_dout;
  logic        valid_din;
  logic        valid_dout;
  logic        data_sel;
  logic        dirty_web0;
  logic [3:0]  dirty_addr0;
  logic        dirty_din0;
  logic        dirty_dout0;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_addr;
  logic        pmem_resp;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  respExp_t respQ[$];
  pmemExp_t pmemQ[$];
  fillExp_t fillQ[$];

  logic [22:0] shadowTag   [16];
  bit          shadowValid [16];
  bit          shadowDirty [16];
  int          expHit  = 0;
  int          expMiss = 0;
  int          expWb   = 0;

  logic [22:0] tagArr   [16];
  logic        validArr [16];
  logic        dirtyArr [16];
  int          pmemCnt;

  cache_ctrl_fsm dut (
    .clk0        (clk0),
    .reset_n     (reset_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_resp    (mem_resp),
    .csb0        (csb0),
    .web0        (web0),
    .set_idx     (set_idx),
    .tag_din     (tag_din),
    .tag_dout    (tag_dout),
    .valid_din   (valid_din),
    .valid_dout  (valid_dout),
    .data_sel    (data_sel),
    .dirty_web0  (dirty_web0),
    .dirty_addr0 (dirty_addr0),
    .dirty_din0  (dirty_din0),
    .dirty_dout0 (dirty_dout0),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_addr   (pmem_addr),
    .pmem_resp   (pmem_resp)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .wb_cnt      (wb_cnt)
`endif
  );

  // Free-running clock.
  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  // Array contents start out invalid and clean; the arrays themselves are
  // not touched by controller reset.
  initial begin
    for (int i = 0; i < 16; i++) begin
      tagArr[i]      = '0;
      validArr[i]    = 1'b0;
      dirtyArr[i]    = 1'b0;
      shadowTag[i]   = '0;
      shadowValid[i] = 1'b0;
      shadowDirty[i] = 1'b0;
    end
  end

  // Behavioural tag/valid and dirty arrays with registered reads.
  always @(posedge clk0) begin
    if (csb0 && web0) begin
      tagArr[set_idx]   <= tag_din;
      validArr[set_idx] <= valid_din;
    end else if (csb0) begin
      tag_dout   <= tagArr[set_idx];
      valid_dout <= validArr[set_idx];
    end
    if (csb0 && dirty_web0) begin
      dirtyArr[dirty_addr0] <= dirty_din0;
    end else if (csb0) begin
      dirty_dout0 <= dirtyArr[dirty_addr0];
    end
  end

  // Physical memory: answers each held request with a one-cycle pulse after
  // PMEM_LAT cycles, and forgets everything on reset.
  always @(posedge clk0) begin
    if (!reset_n) begin
      pmemCnt   <= 0;
      pmem_resp <= 1'b0;
    end else if (pmem_resp) begin
      pmemCnt   <= 0;
      pmem_resp <= 1'b0;
    end else if (pmem_read || pmem_write) begin
      if (pmemCnt == PMEM_LAT - 1) pmem_resp <= 1'b1;
      pmemCnt <= pmemCnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor: each new pmem transfer is matched against the scoreboard, pmem
  // and CPU responses never overlap, mem_resp is a single pulse and every
  // refill write carries the predicted tag and a clean dirty bit.
  logic [1:0] prevPmem = 2'b00;
  bit         prevResp = 1'b0;
  pmemExp_t   pe;
  fillExp_t   fe;

  always @(negedge clk0) begin
    if (pmem_read || pmem_write) begin
      checkOutput("pmemExclusive", {62'b0, pmem_read && pmem_write, mem_resp}, 64'd0);
      if ({pmem_read, pmem_write} != prevPmem) begin
        if (pmemQ.size() == 0) begin
          checkOutput("pmemUnexpected", {31'b0, 1'b1, pmem_write, pmem_addr}, 64'd0);
        end else begin
          pe = pmemQ.pop_front();
          checkOutput("pmemReq", {31'b0, pmem_write, pmem_addr}, {31'b0, pe.isWrite, pe.addr});
        end
      end
    end
    prevPmem = {pmem_read, pmem_write};

    if (csb0 && web0 && data_sel) begin
      if (fillQ.size() == 0) begin
        checkOutput("fillUnexpected", {32'b0, tag_din, 9'b1}, 64'd0);
      end else begin
        fe = fillQ.pop_front();
        checkOutput("fillWrite",
                    {29'b0, tag_din, valid_din, dirty_web0, dirty_din0, dirty_addr0, set_idx},
                    {29'b0, fe.tag, 1'b1, 1'b1, 1'b0, fe.idx, fe.idx});
      end
    end

    if (prevResp) checkOutput("respPulse", {63'b0, mem_resp}, 64'd0);
    prevResp = mem_resp;
  end

  // Predicts the outcome of one request from the shadow cache, pushes the
  // expectations, drives the request and waits for the response. When
  // scramble is set the CPU address is trashed mid-request; when both is
  // set read and write are raised together and the request must act as a
  // write.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                               input bit scramble, input bit both);
    logic [3:0]  idx;
    logic [22:0] tag;
    respExp_t    re;
    int          edges;
    bit          wr;
    idx = addr[8:5];
    tag = addr[31:9];
    wr  = isWrite || both;
    if (shadowValid[idx] && shadowTag[idx] == tag) begin
      expHit++;
      re.lat = 1;
    end else begin
      expMiss++;
      if (shadowValid[idx] && shadowDirty[idx]) begin
        expWb++;
        pmemQ.push_back('{1'b1, {shadowTag[idx], idx, 5'b0}});
        re.lat = 2 * PMEM_LAT + 6;
      end else begin
        re.lat = PMEM_LAT + 5;
      end
      pmemQ.push_back('{1'b0, {tag, idx, 5'b0}});
      fillQ.push_back('{tag, idx});
      shadowValid[idx] = 1'b1;
      shadowTag[idx]   = tag;
      shadowDirty[idx] = 1'b0;
    end
    if (wr) shadowDirty[idx] = 1'b1;
    re.isWrite = wr;
    re.idx     = idx;
    respQ.push_back(re);

    @(posedge clk0);
    #1;
    mem_addr  = addr;
    mem_read  = !isWrite || both;
    mem_write = wr;
    edges = 0;
    forever begin
      @(negedge clk0);
      if (mem_resp) break;
      if (edges > RESP_BOUND) begin
        checkOutput("respTimeout", 64'd1, 64'd0);
        break;
      end
      @(posedge clk0);
      edges++;
      if (scramble && edges == 2) mem_addr = $urandom;
    end
    re = respQ.pop_front();
    checkOutput("respLatency", 64'(edges), 64'(re.lat));
    if (re.isWrite) begin
      checkOutput("writeHitStrobes", {56'b0, web0, data_sel, dirty_web0, dirty_din0, dirty_addr0},
                  {56'b0, 1'b1, 1'b0, 1'b1, 1'b1, re.idx});
    end else begin
      checkOutput("readHitStrobes", {62'b0, web0, dirty_web0}, 64'd0);
    end
  endtask

  task automatic idleCycles(input int n);
    @(posedge clk0);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk0);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "Ctrl"},
                {56'b0, mem_resp, csb0, web0, dirty_web0, dirty_din0, data_sel, valid_din, 1'b0},
                64'd0);
    checkOutput({tag, "Pmem"}, {30'b0, pmem_read, pmem_write, pmem_addr}, 64'd0);
    checkOutput({tag, "Addr"}, {33'b0, set_idx, dirty_addr0, tag_din}, 64'd0);
  endtask

  // Raises a read that must evict a dirty victim, asserts reset once the
  // writeback is on the bus, and checks the controller comes back quiet.
  task automatic resetDuringWb(input logic [31:0] addr);
    logic [3:0] idx;
    int         waitCnt;
    idx = addr[8:5];
    pmemQ.push_back('{1'b1, {shadowTag[idx], idx, 5'b0}});
    @(posedge clk0);
    #1;
    mem_addr = addr;
    mem_read = 1'b1;
    waitCnt  = 0;
    forever begin
      @(negedge clk0);
      if (pmem_write) break;
      waitCnt++;
      if (waitCnt > RESP_BOUND) begin
        checkOutput("wbTimeout", 64'd1, 64'd0);
        break;
      end
    end
    reset_n  = 1'b0;
    mem_read = 1'b0;
    @(posedge clk0);
    #1;
    checkQuiet("wbReset");
    @(posedge clk0);
    #1;
    reset_n = 1'b1;
    checkQuiet("wbResetRelease");
    expHit  = 0;
    expMiss = 0;
    expWb   = 0;
  endtask

  initial begin
    logic [31:0] ra;
    bit          rw;
    reset_n   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    repeat (3) @(posedge clk0);
    #1;
    checkQuiet("reset");
    reset_n = 1'b1;
    idleCycles(2);
    checkQuiet("idle");

    $display("[TB] clean read miss, write hit, dirty eviction");
    applyStimulus(1'b0, 32'h0000_1220, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_1224, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0000_3220, 1'b1, 1'b0);
    idleCycles(2);

    $display("[TB] warm sets 2 and 3, then back-to-back hits");
    applyStimulus(1'b0, 32'h0000_0040, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0060, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 32'h0000_0040, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0060, 1'b0, 1'b0);
    idleCycles(1);

    $display("[TB] read and write together act as a write");
    applyStimulus(1'b0, 32'h0000_0044, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_3224, 1'b0, 1'b0);
    idleCycles(1);

    $display("[TB] reset during writeback, then retry");
    resetDuringWb(32'h0000_1220);
    idleCycles(1);
    applyStimulus(1'b0, 32'h0000_1220, 1'b0, 1'b0);
    idleCycles(1);

    $display("[TB] random traffic over a few sets and tags");
    for (int i = 0; i < 12; i++) begin
      ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
         | 32'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      applyStimulus(rw, ra, 1'b0, 1'b0);
    end
    idleCycles(3);

`ifdef CACHE_PERF_CNT_EN
    checkOutput("hitCnt",  64'(hit_cnt),  64'(expHit));
    checkOutput("missCnt", 64'(miss_cnt), 64'(expMiss));
    checkOutput("wbCnt",   64'(wb_cnt),   64'(expWb));
`endif
    checkOutput("pmemQueueDrained", 64'(pmemQ.size()), 64'd0);
    checkOutput("fillQueueDrained", 64'(fillQ.size()), 64'd0);
    checkQuiet("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
